// File: rtl/mfp_ahb_interconnect.sv
// AHB-lite 1:N interconnect with mask/base address decode, response mux,
// built-in default slave (two-cycle ERROR) and slave wait-state timeout.
module mfp_ahb_interconnect #(
  parameter int unsigned N_SLAVES = 3,
  parameter int unsigned DEC_HI   = 28,
  parameter int unsigned DEC_LO   = 22,
  parameter logic [N_SLAVES*(DEC_HI-DEC_LO+1)-1:0] SLAVE_BASE = {7'h7E, 7'h00, 7'h7F},
  parameter logic [N_SLAVES*(DEC_HI-DEC_LO+1)-1:0] SLAVE_MASK = {7'h7F, 7'h40, 7'h7F},
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  output logic [31:0]            HRDATA,
  output logic                   HREADY,
  output logic                   HRESP,
  output logic [N_SLAVES-1:0]    HSEL_S,
  input  logic [32*N_SLAVES-1:0] HRDATA_S,
  input  logic [N_SLAVES-1:0]    HREADYOUT_S,
  input  logic [N_SLAVES-1:0]    HRESP_S
);

  localparam int unsigned W  = DEC_HI - DEC_LO + 1;
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic TO_EN = (TIMEOUT != 0);

  localparam logic [1:0] NORMAL = 2'd0;
  localparam logic [1:0] ERR1   = 2'd1;
  localparam logic [1:0] ERR2   = 2'd2;

  logic [1:0]          state, state_nx;
  logic [N_SLAVES-1:0] sel_d, sel_nx;
  logic [CW-1:0]       count, count_nx;
  logic [W-1:0]        field;
  logic                found;
  logic                unmapped;
  logic [31:0]         mux_data;
  logic                mux_ready;
  logic                mux_resp;
  logic                unused_addr;

  assign field       = HADDR[DEC_HI:DEC_LO];
  assign unused_addr = ^{HADDR, HTRANS};

  // Priority decode: lowest matching index wins
  always_comb begin
    HSEL_S = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (!found && ((field & SLAVE_MASK[i*W +: W]) == SLAVE_BASE[i*W +: W])) begin
        HSEL_S[i] = 1'b1;
        found     = 1'b1;
      end
    end
    unmapped = !found && HTRANS[1];
  end

  // Response mux over the one-hot data-phase select
  always_comb begin
    mux_data  = '0;
    mux_ready = 1'b0;
    mux_resp  = 1'b0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (sel_d[i]) begin
        mux_data  = mux_data | HRDATA_S[i*32 +: 32];
        mux_ready = mux_ready | HREADYOUT_S[i];
        mux_resp  = mux_resp | HRESP_S[i];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    case (state)
      NORMAL: begin
        if (sel_d != '0) begin
          HRDATA = mux_data;
          HREADY = mux_ready;
          HRESP  = mux_resp;
        end
      end
      ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      ERR2: begin
        HRESP  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel_d;
    count_nx = count;
    case (state)
      NORMAL: begin
        if (HREADY) begin
          sel_nx   = HSEL_S & {N_SLAVES{HTRANS[1]}};
          count_nx = '0;
          if (unmapped) state_nx = ERR1;
        end else if (TO_EN && sel_d != '0) begin
          // Final wait cycle before the limit aborts the hung slave
          if (count == TO_LAST) begin
            state_nx = ERR1;
            sel_nx   = '0;
            count_nx = '0;
          end else begin
            count_nx = count + CW'(1);
          end
        end
      end
      ERR1: state_nx = ERR2;
      ERR2: begin
        sel_nx   = HSEL_S & {N_SLAVES{HTRANS[1]}};
        count_nx = '0;
        state_nx = unmapped ? ERR1 : NORMAL;
      end
      default: state_nx = NORMAL;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= NORMAL;
      sel_d <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      sel_d <= sel_nx;
      count <= count_nx;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// Bench for mfp_ahb_interconnect: transaction-level reference model of the
// expected response beats, driven with directed and random AHB transfers.
module tb_mfp_ahb_interconnect;

  localparam int TMO = 8;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [2:0]  HSEL_S;
  logic [95:0] HRDATA_S;
  logic [2:0]  HREADYOUT_S;
  logic [2:0]  HRESP_S;

  logic [2:0]  ovl_hsel;
  logic [31:0] unused_ovl_rdata;
  logic        unused_ovl_ready;
  logic        unused_ovl_resp;

  int tests = 0;
  int fails = 0;

  // Pending data phase: kind 0 = none, 1 = slave, 2 = unmapped
  int          p_kind = 0;
  int          p_slave = 0;
  int          p_waits = 0;
  logic [31:0] p_data = '0;
  logic        p_serr = 1'b0;

  int base_tab [3] = '{'h7F, 'h00, 'h7E};
  int mask_tab [3] = '{'h7F, 'h40, 'h7F};

  mfp_ahb_interconnect #(.TIMEOUT(TMO)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HSEL_S(HSEL_S),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S)
  );

  // Overlapping map: slave0 matches every address
  mfp_ahb_interconnect #(
    .SLAVE_BASE({7'h7E, 7'h00, 7'h00}),
    .SLAVE_MASK({7'h7F, 7'h40, 7'h00}),
    .TIMEOUT(0)
  ) u_ovl (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HRDATA(unused_ovl_rdata), .HREADY(unused_ovl_ready), .HRESP(unused_ovl_resp),
    .HSEL_S(ovl_hsel), .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int decode(input logic [31:0] addr);
    int f;
    f = int'((addr >> 22) & 32'h7F);
    for (int i = 0; i < 3; i++)
      if ((f & mask_tab[i]) == base_tab[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] exp_hsel(input logic [31:0] addr);
    int d;
    d = decode(addr);
    return (d < 0) ? 3'b000 : 3'(1 << d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_slaves(input int s, input logic rdy, input logic rsp, input logic [31:0] d);
    HRDATA_S    = {$urandom, $urandom, $urandom};
    HREADYOUT_S = 3'($urandom);
    HRESP_S     = 3'($urandom);
    if (s >= 0) begin
      HRDATA_S[s*32 +: 32] = d;
      HREADYOUT_S[s]       = rdy;
      HRESP_S[s]           = rsp;
    end
  endtask

  // Check one cycle's outputs, then advance to just after the next edge
  task automatic cycle_chk(input logic er, input logic ep, input logic dchk,
                           input logic [31:0] ed, input string tag);
    #2;
    chk({tag, "_hready"}, 32'(HREADY), 32'(er));
    chk({tag, "_hresp"}, 32'(HRESP), 32'(ep));
    if (dchk) chk({tag, "_hrdata"}, HRDATA, ed);
    chk("hsel", 32'(HSEL_S), 32'(exp_hsel(HADDR)));
    chk("ovl_hsel", 32'(ovl_hsel), 32'h1);
    @(posedge HCLK);
    #1;
  endtask

  // Present a new address phase while completing the pending data phase
  task automatic issue(input logic [31:0] addr, input logic [1:0] trans, input int waits,
                       input logic [31:0] data, input logic serr);
    int d;
    HADDR  = addr;
    HTRANS = trans;
    case (p_kind)
      0: begin
        drive_slaves(-1, 1'b0, 1'b0, '0);
        cycle_chk(1'b1, 1'b0, 1'b1, '0, "idle");
      end
      2: begin
        drive_slaves(-1, 1'b0, 1'b0, '0);
        cycle_chk(1'b0, 1'b1, 1'b1, '0, "err1");
        drive_slaves(-1, 1'b0, 1'b0, '0);
        cycle_chk(1'b1, 1'b1, 1'b1, '0, "err2");
      end
      default: begin
        if (p_waits >= TMO) begin
          for (int k = 0; k < TMO; k++) begin
            drive_slaves(p_slave, 1'b0, 1'b0, $urandom);
            cycle_chk(1'b0, 1'b0, 1'b0, '0, "to_wait");
          end
          drive_slaves(p_slave, 1'b1, 1'b0, p_data);
          cycle_chk(1'b0, 1'b1, 1'b1, '0, "to_err1");
          drive_slaves(p_slave, 1'b1, 1'b0, p_data);
          cycle_chk(1'b1, 1'b1, 1'b1, '0, "to_err2");
        end else begin
          for (int k = 0; k < p_waits; k++) begin
            drive_slaves(p_slave, 1'b0, 1'b0, $urandom);
            cycle_chk(1'b0, 1'b0, 1'b0, '0, "wait");
          end
          if (p_serr) begin
            drive_slaves(p_slave, 1'b0, 1'b1, $urandom);
            cycle_chk(1'b0, 1'b1, 1'b0, '0, "serr1");
          end
          drive_slaves(p_slave, 1'b1, p_serr, p_data);
          cycle_chk(1'b1, p_serr, 1'b1, p_data, "data");
        end
      end
    endcase
    d = decode(addr);
    p_slave = d;
    p_waits = waits;
    p_data  = data;
    p_serr  = serr;
    p_kind  = !trans[1] ? 0 : (d < 0 ? 2 : 1);
  endtask

  // Assert reset during the first cycle of the pending data phase
  task automatic reset_mid();
    HADDR  = '0;
    HTRANS = 2'b00;
    HRESET = 1'b1;
    if (p_kind == 2) begin
      drive_slaves(-1, 1'b0, 1'b0, '0);
      cycle_chk(1'b0, 1'b1, 1'b1, '0, "rst_err1");
    end else begin
      drive_slaves(p_slave, 1'b0, 1'b0, $urandom);
      cycle_chk(1'b0, 1'b0, 1'b0, '0, "rst_wait");
    end
    HRESET = 1'b0;
    drive_slaves(-1, 1'b0, 1'b0, '0);
    cycle_chk(1'b1, 1'b0, 1'b1, '0, "post_rst");
    p_kind = 0;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  t;
    int          w, r;
    logic        se;

    HRESET = 1'b1;
    HADDR  = '0;
    HTRANS = 2'b00;
    drive_slaves(-1, 1'b0, 1'b0, '0);
    @(posedge HCLK);
    #1;
    cycle_chk(1'b1, 1'b0, 1'b1, '0, "reset");
    HRESET = 1'b0;

    issue(32'hBFC00010, 2'b10, 0, 32'h12345678, 1'b0);
    issue(32'h80000040, 2'b10, 3, 32'hCAFE0001, 1'b0);
    issue(32'hBF000000, 2'b10, 0, '0, 1'b0);
    issue(32'hBF800000, 2'b10, 100, 32'hDEAD0002, 1'b0);
    issue(32'hBFC00020, 2'b10, 0, 32'h0BADF00D, 1'b0);
    issue(32'hBF000000, 2'b10, 0, '0, 1'b0);
    issue(32'hBF000004, 2'b11, 0, '0, 1'b0);
    issue(32'hBF000008, 2'b10, 0, '0, 1'b0);
    reset_mid();
    issue(32'hBF000000, 2'b00, 0, '0, 1'b0);
    issue(32'h80000100, 2'b10, 5, 32'h55AA55AA, 1'b0);
    reset_mid();
    issue(32'h80001000, 2'b10, 2, 32'h76543210, 1'b1);
    issue(32'hBF800010, 2'b01, 0, '0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      r = $urandom_range(0, 3);
      if (r == 0) a[28:22] = 7'h7F;
      else if (r == 1) a[28:22] = 7'h7E;
      r = $urandom_range(0, 5);
      t = (r < 2) ? 2'(r) : ((r < 4) ? 2'b10 : 2'b11);
      w = $urandom_range(0, 9);
      se = ($urandom_range(0, 5) == 0);
      if (se && w > TMO - 2) w = TMO - 2;
      issue(a, t, w, $urandom, se);
    end
    issue(32'h0, 2'b00, 0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
